// File: rtl/uart_pkg.sv
// Shared UART definitions: TX FSM state encoding, parity selects and line levels.
// Line-level constants are also used by the RX frame checkers.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_e;

  localparam logic PAR_EVEN   = 1'b0;
  localparam logic PAR_ODD    = 1'b1;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/tx_serializer.sv
// Load-on-accept shift register and bit counter for the UART transmitter.
// o_cur_bit is the bit on the line during DATA; o_next_bit is the one that follows it.
module tx_serializer #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  i_load,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_shift,
  output logic                  o_cur_bit,
  output logic                  o_next_bit,
  output logic                  o_last
);

  localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] r_shift;
  logic [CNT_W-1:0]      r_cnt;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_load) begin
      r_shift <= i_data;
      r_cnt   <= '0;
    end else if (i_shift) begin
      r_shift <= {1'b0, r_shift[DATA_WIDTH-1:1]};
      r_cnt   <= r_cnt + 1'b1;
    end
  end

  assign o_cur_bit  = r_shift[0];
  assign o_next_bit = r_shift[1];
  assign o_last     = (r_cnt == LAST_IDX);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity, stop bit.
// Parity is only built when UART_TX_PARITY_EN is defined; otherwise PAR_EN/PAR_TYP are ignored.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  busy
);

  tx_state_e r_state, w_state_next;
  logic      r_tx_out, w_tx_next;
  logic      r_busy, w_busy_next;
  logic      w_load, w_shift;
  logic      w_cur_bit, w_next_bit, w_last;

`ifdef UART_TX_PARITY_EN
  logic r_par_en;
  logic r_par;

  // Seeding with PAR_TYP turns the running XOR into odd parity when requested.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_par_en <= 1'b0;
      r_par    <= PAR_EVEN;
    end else if (w_load) begin
      r_par_en <= PAR_EN;
      r_par    <= PAR_TYP;
    end else if (w_shift) begin
      r_par    <= r_par ^ w_cur_bit;
    end
  end
`else
  logic w_unused_par;
  assign w_unused_par = PAR_EN ^ PAR_TYP;
`endif

  tx_serializer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ser (
    .CLK        (CLK),
    .RST        (RST),
    .i_load     (w_load),
    .i_data     (P_DATA),
    .i_shift    (w_shift),
    .o_cur_bit  (w_cur_bit),
    .o_next_bit (w_next_bit),
    .o_last     (w_last)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state  <= StIdle;
      r_tx_out <= IDLE_LEVEL;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_tx_out <= w_tx_next;
      r_busy   <= w_busy_next;
    end
  end

  // Outputs are registered, so each branch computes the line value of the next state.
  always_comb begin
    w_state_next = r_state;
    w_tx_next    = IDLE_LEVEL;
    w_busy_next  = 1'b1;
    w_load       = 1'b0;
    w_shift      = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_busy_next = 1'b0;
        if (Data_Valid) begin
          w_load       = 1'b1;
          w_state_next = StStart;
          w_tx_next    = START_BIT;
          w_busy_next  = 1'b1;
        end
      end
      StStart: begin
        w_state_next = StData;
        w_tx_next    = w_cur_bit;
      end
      StData: begin
        w_shift = 1'b1;
        if (!w_last) begin
          w_tx_next = w_next_bit;
        end else begin
          w_state_next = StStop;
          w_tx_next    = STOP_BIT;
`ifdef UART_TX_PARITY_EN
          if (r_par_en) begin
            w_state_next = StParity;
            w_tx_next    = r_par ^ w_cur_bit;
          end
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        w_state_next = StStop;
        w_tx_next    = STOP_BIT;
      end
`endif
      StStop: begin
        w_state_next = StIdle;
        w_tx_next    = IDLE_LEVEL;
        w_busy_next  = 1'b0;
      end
      default: begin
        w_state_next = StIdle;
        w_busy_next  = 1'b0;
      end
    endcase
  end

  assign TX_OUT = r_tx_out;
  assign busy   = r_busy;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues hand-written frames, a negedge monitor checks them.
// Expected frames follow UART_TX_PARITY_EN when the bench is compiled with it.
module tb_uart_tx;

  logic       CLK;
  logic       RST;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       TX_OUT;
  logic       busy;

  uart_tx #(
    .DATA_WIDTH (8)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .TX_OUT     (TX_OUT),
    .busy       (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic tx;
    logic last;
  } exp_t;

  exp_t exp_q[$];
  int   starts[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  bit   mon_en   = 1'b0;
  bit   in_frame = 1'b0;
  bit   after_last = 1'b0;
  logic prev_busy = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Frame bits are given in line order, first bit in the MSB of the n used.
  task automatic push_frame(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      exp_q.push_back('{tx: bits[i], last: (i == 0)});
    end
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (busy && !prev_busy) starts.push_back(cyc);
    prev_busy = busy;
    if (!mon_en) begin
      in_frame   = 1'b0;
      after_last = 1'b0;
    end else if (busy) begin
      if (after_last) check("busy_too_long", {31'd0, busy}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_frame", {31'd0, busy}, 32'd0);
        after_last = 1'b0;
      end else begin
        e = exp_q.pop_front();
        check("tx_bit", {31'd0, TX_OUT}, {31'd0, e.tx});
        in_frame   = !e.last;
        after_last = e.last;
      end
    end else begin
      if (in_frame) check("busy_too_short", {31'd0, busy}, 32'd1);
      in_frame   = 1'b0;
      after_last = 1'b0;
      check("idle_line", {31'd0, TX_OUT}, 32'd1);
    end
  end

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 40) begin
      @(negedge CLK);
      k++;
    end
    check("idle_timeout", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge CLK);
  endtask

  task automatic send(input logic [7:0] d, input logic pe, input logic pt,
                      input logic [15:0] bits, input int n, input bit mid);
    push_frame(bits, n);
    @(negedge CLK);
    P_DATA = d; PAR_EN = pe; PAR_TYP = pt; Data_Valid = 1'b1;
    @(negedge CLK);
    Data_Valid = 1'b0;
    if (mid) begin
      repeat (3) @(negedge CLK);
      P_DATA = 8'h00; PAR_EN = ~pe; PAR_TYP = ~pt; Data_Valid = 1'b1;
      @(negedge CLK);
      Data_Valid = 1'b0;
    end
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b0; Data_Valid = 1'b1; P_DATA = 8'hFF; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    repeat (4) begin
      @(negedge CLK);
      check("rst_tx", {31'd0, TX_OUT}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd0);
    end
    @(negedge CLK);
    Data_Valid = 1'b0; RST = 1'b1; mon_en = 1'b1;
    repeat (5) @(negedge CLK);

    // 0xA5 LSB first is 1,0,1,0,0,1,0,1.
    send(8'hA5, 1'b0, 1'b0, 16'b0101001011, 10, 1'b0);
`ifdef UART_TX_PARITY_EN
    send(8'hA5, 1'b1, 1'b0, 16'b01010010101, 11, 1'b0);
    send(8'hA5, 1'b1, 1'b1, 16'b01010010111, 11, 1'b0);
    send(8'h07, 1'b1, 1'b0, 16'b01110000011, 11, 1'b1);
`else
    send(8'hA5, 1'b1, 1'b0, 16'b0101001011, 10, 1'b0);
    send(8'hA5, 1'b1, 1'b1, 16'b0101001011, 10, 1'b0);
    send(8'h07, 1'b1, 1'b0, 16'b0111000001, 10, 1'b1);
`endif

    // Back-to-back: 0x3C held valid across three frames.
    for (int f = 0; f < 3; f++) push_frame(16'b0001111001, 10);
    starts.delete();
    @(negedge CLK);
    P_DATA = 8'h3C; PAR_EN = 1'b0; PAR_TYP = 1'b0; Data_Valid = 1'b1;
    repeat (23) @(negedge CLK);
    Data_Valid = 1'b0;
    wait_idle();
    check("b2b_frames", starts.size(), 32'd3);
    if (starts.size() >= 3) begin
      check("b2b_period1", starts[1] - starts[0], 32'd11);
      check("b2b_period2", starts[2] - starts[1], 32'd11);
    end

    // Reset during data bit 4 of 0xA5 (bit 4 is 0).
    @(negedge CLK);
    mon_en = 1'b0;
    P_DATA = 8'hA5; PAR_EN = 1'b0; Data_Valid = 1'b1;
    @(negedge CLK);
    Data_Valid = 1'b0;
    check("mid_start_tx", {31'd0, TX_OUT}, 32'd0);
    check("mid_start_busy", {31'd0, busy}, 32'd1);
    repeat (5) @(negedge CLK);
    check("mid_bit4_tx", {31'd0, TX_OUT}, 32'd0);
    #1 RST = 1'b0;
    #1;
    check("mid_rst_tx", {31'd0, TX_OUT}, 32'd1);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    mon_en = 1'b1;
    send(8'hA5, 1'b0, 1'b0, 16'b0101001011, 10, 1'b0);

    repeat (3) @(negedge CLK);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter side of the UART: accepts one parallel word per handshake and emits a standard asynchronous frame (start bit, data LSB-first, optional parity, stop bit) on a single line. One frame bit per CLK cycle; CLK is the TX bit clock from the baud-rate divider. It is the transmit counterpart of the RX path, and the stop and parity bits it generates are what the RX checkers verify.

## Interface
- DATA_WIDTH, 8, width of the parallel data word
- CLK  input  1  TX bit clock; all state changes on the rising edge
- RST  input  1  asynchronous, active-low reset
- P_DATA  input  DATA_WIDTH  parallel word to send; sampled only on acceptance
- Data_Valid  input  1  request to send P_DATA
- PAR_EN  input  1  1 = append parity bit; sampled on acceptance
- PAR_TYP  input  1  0 = even, 1 = odd; sampled on acceptance
- TX_OUT  output  1  serial line; idles high
- busy  output  1  high while a frame is in progress

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: TX_OUT=1, busy=0. The frame is accepted on a rising edge with Data_Valid=1 in IDLE. P_DATA, PAR_EN and PAR_TYP are latched on that edge, and the next state is START.
- START: TX_OUT=0, busy=1, for 1 cycle. Next state is DATA.
- DATA: TX_OUT = latched data bit, LSB first, for DATA_WIDTH cycles. A bit counter runs from 0 to DATA_WIDTH-1. At the last bit, the next state is PARITY if the latched PAR_EN=1, otherwise STOP.
- PARITY: TX_OUT = ^data for even parity, ~^data for odd parity, for 1 cycle. Next state is STOP.
- STOP: TX_OUT=1 for 1 cycle. Next state is IDLE.
- Data_Valid is ignored while not in IDLE. Input changes mid-frame have no effect on the current frame.
- Parity is computed from the latched word, never from live P_DATA.
- TX_OUT and busy are registered outputs. They are glitch-free, with no combinational path from any input.

## Timing
- Reset values: TX_OUT=1, busy=0, state IDLE, counter 0, latched data 0.
- Latency: the start bit appears on TX_OUT in the cycle after the accepting edge. busy rises in that same cycle.
- Frame length: DATA_WIDTH+2 cycles without parity, DATA_WIDTH+3 with parity. busy is high for exactly that many cycles.
- busy falls in the cycle after the stop bit.
- Back-to-back frames: a request held high is accepted on the first edge in IDLE. This gives a minimum of 1 idle-high cycle between frames, so the frame period is DATA_WIDTH+3 (no parity) or DATA_WIDTH+4 (parity).
- Reset mid-frame: TX_OUT=1 and busy=0 immediately (asynchronous). The frame is dropped, and after RST deasserts the block resumes in IDLE.
- Data_Valid asserted during reset is not accepted. The earliest acceptance is the first rising edge with RST=1.

## Configuration
- UART_TX_PARITY_EN defined: the PARITY state, the parity generator and the PAR_EN/PAR_TYP latches are built. Behaviour is as described above.
- Not defined: no PARITY state or parity logic is built. PAR_EN and PAR_TYP remain as ports but are ignored. Every frame is DATA_WIDTH+2 bits.

## Structure
- Shared package uart_pkg holds:
  - state enum encoding (IDLE/START/DATA/PARITY/STOP);
  - PAR_EVEN/PAR_ODD constants;
  - line-level constants START_BIT=0, STOP_BIT=1 and IDLE_LEVEL=1 (shared with RX checkers).
- One sub-module is natural: tx_serializer. It contains the load-on-accept shift register plus the $clog2(DATA_WIDTH) bit counter, with a last-bit flag back to the FSM.
- FSM, parity generation and the output mux stay in uart_tx.

## Test plan
- Reset: hold RST=0 with Data_Valid=1 and P_DATA=0xFF → TX_OUT=1 and busy=0 throughout; nothing is sent after release until Data_Valid is re-sampled in IDLE.
- P_DATA=0xA5, PAR_EN=0 → TX_OUT over 10 cycles = 0,1,0,1,0,0,1,0,1,1; busy high exactly 10 cycles, then low.
- P_DATA=0xA5, PAR_EN=1, PAR_TYP=0 → parity bit 0 (four ones), 11-bit frame. Repeat with PAR_TYP=1 → parity bit 1.
- P_DATA=0x07, PAR_EN=1, PAR_TYP=0 → parity bit 1. Change P_DATA to 0x00 mid-frame → transmitted bits and parity unchanged.
- Data_Valid held high for 3 frames, PAR_EN=0 → each frame is 10 bits with exactly 1 idle-high cycle between frames (period 11 cycles).
- RST pulsed low during data bit 4 → TX_OUT=1 and busy=0 immediately; the next request yields a complete, correct frame.
- Build without UART_TX_PARITY_EN, PAR_EN=1 → frame is still 10 bits with no parity bit.
